bexkat2_timer_target: RTL and testbench



---
 rtl/bexkat2_timer_target_pkg.sv | 49 ++++
 rtl/bexkat2_timer_target_if.sv | 28 ++
 rtl/bexkat2_timer_target_prescaler.sv | 38 +++
 rtl/bexkat2_timer_target.sv | 209 ++++++++++++++++++++
 tb/tb_bexkat2_timer_target.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bexkat2_timer_target_pkg.sv
// bexkat2 timer target: shared register offsets, bus FSM states and
// STATUS/CTRL bit positions, plus a byte-lane merge helper.
package bexkat2TimerDef;

    // Word offsets of the register file. Offsets 8..15 are unmapped.
    typedef enum logic [3:0] {
        TMR_CTRL     = 4'd0,
        TMR_STATUS   = 4'd1,
        TMR_COUNT    = 4'd2,
        TMR_PRESCALE = 4'd3,
        TMR_CMP0     = 4'd4,
        TMR_CMP1     = 4'd5,
        TMR_CMP2     = 4'd6,
        TMR_CMP3     = 4'd7
    } tmr_reg_e;

    // Bus responder states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } bus_state_e;

    // STATUS bit positions.
    localparam int STATUS_CMP0 = 0;
    localparam int STATUS_CMP1 = 1;
    localparam int STATUS_CMP2 = 2;
    localparam int STATUS_CMP3 = 3;
    localparam int STATUS_WRAP = 4;
    localparam int STATUS_W    = 5;

    // CTRL layout: bit 0 enables counting, bits 8:4 enable irq per STATUS bit.
    localparam int          CTRL_EN      = 0;
    localparam int          CTRL_IRQ_LSB = 4;
    localparam logic [31:0] CTRL_MASK    = 32'h0000_01F1;

    // Replace only the byte lanes flagged in sel; other lanes keep old_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bexkat2_timer_target_if.sv
// Wishbone-classic bus bundle between the bexkat2 CPU (master) and the
// timer target (slave). Signal names keep the target-side _i/_o suffixes.
//
// Handshake: the master raises cyc_i&stb_i and holds we_i/adr_i/sel_i/dat_i
// stable until it sees a single-cycle ack_o or err_o pulse; that pulse is the
// only completion signal and dat_o is valid only while it is high. Dropping
// cyc_i before the pulse abandons the access with no side effect.
interface bexkat2_timer_target_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/bexkat2_timer_target_prescaler.sv
// Prescaler for the timer: counts enabled cycles and emits a one-cycle tick
// every PRESCALE+1 cycles. clr_i restarts the division from zero and
// suppresses the tick in that cycle.
module bexkat2_prescaler (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [31:0] prescale_i,
    output logic        tick_o
);

    logic [31:0] pcnt_q, pcnt_d;

    // Next divider value and tick; >= keeps the divider from running away
    // when PRESCALE is lowered below the current count.
    always_comb begin
        pcnt_d = pcnt_q;
        tick_o = 1'b0;
        if (clr_i) begin
            pcnt_d = '0;
        end else if (en_i) begin
            if (pcnt_q >= prescale_i) begin
                pcnt_d = '0;
                tick_o = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 32'd1;
            end
        end
    end

    // Divider register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pcnt_q <= '0;
        else          pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/bexkat2_timer_target.sv
// bexkat2 timer target: Wishbone-classic responder with a prescaled 32-bit
// free-running counter, four compare registers and a level interrupt.
// Optional macro BEXKAT2_TIMER_ERR_EN: accesses to word addresses 8..15 end
// with err_o instead of ack_o.
module bexkat2_timer_target
    import bexkat2TimerDef::*;
#(
    parameter int          WAIT_STATES    = 0,
    parameter logic [31:0] RESET_PRESCALE = 32'h0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    bexkat2_timer_target_if.slave  bus,
    output logic                   irq_o,
    output bus_state_e             dbg_state_o
);

    localparam int         WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [2:0] WAIT_LOAD   = 3'(WAIT_LOAD_I);

    bus_state_e state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0]         ctrl_q, ctrl_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [31:0]         count_q, count_d;
    logic [31:0]         prescale_q, prescale_d;
    logic [31:0]         cmp_q [4];
    logic [31:0]         cmp_d [4];
    logic                irq_q, irq_d;

    logic                req;
    logic                acc_err;
    logic                wr_commit;
    logic                count_wr;
    logic                tick;
    logic [31:0]         rd_data;
    logic [31:0]         count_inc;
    logic [STATUS_W-1:0] hw_set;
    logic [STATUS_W-1:0] w1c;

    assign req = bus.cyc_i & bus.stb_i;

`ifdef BEXKAT2_TIMER_ERR_EN
    assign acc_err = bus.adr_i[3];
`else
    assign acc_err = 1'b0;
`endif

    // A write lands only in the ack cycle and only on mapped offsets.
    assign wr_commit = (state_q == S_ACK) && bus.we_i && !bus.adr_i[3];
    assign count_wr  = wr_commit && (bus.adr_i == TMR_COUNT);

    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.dat_o   = dat_q;
    assign irq_o       = irq_q;
    assign dbg_state_o = state_q;

    bexkat2_prescaler u_prescaler (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .en_i       (ctrl_q[CTRL_EN]),
        .clr_i      (count_wr),
        .prescale_i (prescale_q),
        .tick_o     (tick)
    );

    // Read mux; unmapped offsets read as zero.
    always_comb begin
        rd_data = '0;
        case (bus.adr_i)
            TMR_CTRL:     rd_data = ctrl_q;
            TMR_STATUS:   rd_data = {{(32-STATUS_W){1'b0}}, status_q};
            TMR_COUNT:    rd_data = count_q;
            TMR_PRESCALE: rd_data = prescale_q;
            TMR_CMP0:     rd_data = cmp_q[0];
            TMR_CMP1:     rd_data = cmp_q[1];
            TMR_CMP2:     rd_data = cmp_q[2];
            TMR_CMP3:     rd_data = cmp_q[3];
            default:      rd_data = '0;
        endcase
    end

    // Bus FSM: optional wait countdown, then a single ack/err cycle whose
    // read data is captured on entry.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = S_ACK;
                        ack_d   = !acc_err;
                        err_d   = acc_err;
                        dat_d   = rd_data;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.cyc_i) begin
                    state_d = S_IDLE;
                end else if (wait_q == 3'd0) begin
                    state_d = S_ACK;
                    ack_d   = !acc_err;
                    err_d   = acc_err;
                    dat_d   = rd_data;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                dat_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                dat_d   = '0;
            end
        endcase
    end

    // Register file update: bus writes, counting, match/wrap flags, irq.
    always_comb begin
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        for (int n = 0; n < 4; n++) cmp_d[n] = cmp_q[n];
        w1c       = '0;
        hw_set    = '0;
        count_inc = count_q + 32'd1;

        if (wr_commit) begin
            case (bus.adr_i)
                TMR_CTRL:     ctrl_d = byte_merge(ctrl_q, bus.dat_i, bus.sel_i) & CTRL_MASK;
                TMR_STATUS:   w1c = bus.sel_i[0] ? bus.dat_i[STATUS_W-1:0] : '0;
                TMR_PRESCALE: prescale_d = byte_merge(prescale_q, bus.dat_i, bus.sel_i);
                TMR_CMP0:     cmp_d[0] = byte_merge(cmp_q[0], bus.dat_i, bus.sel_i);
                TMR_CMP1:     cmp_d[1] = byte_merge(cmp_q[1], bus.dat_i, bus.sel_i);
                TMR_CMP2:     cmp_d[2] = byte_merge(cmp_q[2], bus.dat_i, bus.sel_i);
                TMR_CMP3:     cmp_d[3] = byte_merge(cmp_q[3], bus.dat_i, bus.sel_i);
                default:      ;
            endcase
        end

        // A COUNT write takes priority over the increment; compares use the
        // compare values held before any same-cycle CMP write.
        if (count_wr) begin
            count_d = byte_merge(count_q, bus.dat_i, bus.sel_i);
        end else if (tick) begin
            count_d = count_inc;
            for (int n = 0; n < 4; n++) begin
                if (count_inc == cmp_q[n]) hw_set[STATUS_CMP0 + n] = 1'b1;
            end
            if (count_q == 32'hFFFF_FFFF) hw_set[STATUS_WRAP] = 1'b1;
        end

        // Hardware set wins over a coincident write-1-to-clear.
        status_d = (status_q & ~w1c) | hw_set;
        irq_d    = |(status_q & ctrl_q[CTRL_IRQ_LSB +: STATUS_W]);
    end

    // Bus FSM registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // Timer registers and interrupt output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q     <= '0;
            status_q   <= '0;
            count_q    <= '0;
            prescale_q <= RESET_PRESCALE;
            for (int n = 0; n < 4; n++) cmp_q[n] <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            status_q   <= status_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            for (int n = 0; n < 4; n++) cmp_q[n] <= cmp_d[n];
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_bexkat2_timer_target.sv
// Bench for bexkat2_timer_target: a zero-wait instance (RESET_PRESCALE=0x10)
// checked against a cycle-level register model, and a three-wait instance
// for latency and abandoned-cycle behaviour.
module tb_bexkat2_timer_target;
    import bexkat2TimerDef::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bexkat2_timer_target_if bus_a ();
    bexkat2_timer_target_if bus_b ();

    logic       irq_a, irq_b;
    bus_state_e dbg_a, dbg_b;

    bexkat2_timer_target #(.WAIT_STATES(0), .RESET_PRESCALE(32'h10)) dut_a (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bus         (bus_a),
        .irq_o       (irq_a),
        .dbg_state_o (dbg_a)
    );

    bexkat2_timer_target #(.WAIT_STATES(3), .RESET_PRESCALE(32'h0)) dut_b (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bus         (bus_b),
        .irq_o       (irq_b),
        .dbg_state_o (dbg_b)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model of dut_a ----------------
    logic [31:0] m_ctrl, m_count, m_pre, m_pcnt;
    logic [4:0]  m_status;
    logic [31:0] m_cmp [4];
    logic        m_irq;
    logic        p_wr;
    logic [3:0]  p_adr, p_sel;
    logic [31:0] p_dat;

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_count = 0; m_pre = 32'h10; m_pcnt = 0; m_status = 0; m_irq = 0;
        for (int n = 0; n < 4; n++) m_cmp[n] = 0;
        p_wr = 0; p_adr = 0; p_sel = 0; p_dat = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] adr);
        case (adr)
            4'd0: return m_ctrl;
            4'd1: return {27'd0, m_status};
            4'd2: return m_count;
            4'd3: return m_pre;
            4'd4: return m_cmp[0];
            4'd5: return m_cmp[1];
            4'd6: return m_cmp[2];
            4'd7: return m_cmp[3];
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge, consuming the pending write.
    task automatic model_edge();
        logic        cwr, tk, nxt_irq;
        logic [4:0]  hw, clr;
        nxt_irq = |(m_status & m_ctrl[8:4]);
        cwr = p_wr && (p_adr == 4'd2);
        clr = (p_wr && p_adr == 4'd1 && p_sel[0]) ? p_dat[4:0] : 5'd0;
        tk  = 0;
        hw  = 0;
        if (cwr) m_pcnt = 0;
        else if (m_ctrl[0]) begin
            if (m_pcnt >= m_pre) begin tk = 1; m_pcnt = 0; end
            else m_pcnt = m_pcnt + 1;
        end
        if (cwr) m_count = lanes(m_count, p_dat, p_sel);
        else if (tk) begin
            if (m_count == 32'hFFFF_FFFF) hw[4] = 1;
            m_count = m_count + 1;
            for (int n = 0; n < 4; n++) if (m_count == m_cmp[n]) hw[n] = 1;
        end
        m_status = (m_status & ~clr) | hw;
        if (p_wr) begin
            case (p_adr)
                4'd0: m_ctrl = lanes(m_ctrl, p_dat, p_sel) & 32'h1F1;
                4'd3: m_pre = lanes(m_pre, p_dat, p_sel);
                4'd4, 4'd5, 4'd6, 4'd7: m_cmp[p_adr - 4'd4] = lanes(m_cmp[p_adr - 4'd4], p_dat, p_sel);
                default: ;
            endcase
        end
        m_irq = nxt_irq;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model follows the edge, outputs checked at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        p_wr = 0;
        @(negedge clk);
        chk("irq_a", 32'(irq_a), 32'(m_irq));
    endtask

    task automatic acc_a(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rd);
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = 1'b0;
`ifdef BEXKAT2_TIMER_ERR_EN
        exp_err = adr[3];
`endif
        exp_rd = exp_err ? 32'd0 : model_read(adr);
        bus_a.cyc_i = 1; bus_a.stb_i = 1; bus_a.we_i = we;
        bus_a.adr_i = adr; bus_a.sel_i = sel; bus_a.dat_i = dat;
        step();
        chk("a_ack", 32'(bus_a.ack_o), 32'(!exp_err));
        chk("a_err", 32'(bus_a.err_o), 32'(exp_err));
        if (!we) chk("a_rdata", bus_a.dat_o, exp_rd);
        rd = bus_a.dat_o;
        p_wr = we && !adr[3]; p_adr = adr; p_sel = sel; p_dat = dat;
        step();
        chk("a_ack_pulse", 32'(bus_a.ack_o | bus_a.err_o), 32'd0);
        bus_a.cyc_i = 0; bus_a.stb_i = 0; bus_a.we_i = 0;
    endtask

    task automatic acc_b(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output int lat, output logic [31:0] rd);
        bus_b.cyc_i = 1; bus_b.stb_i = 1; bus_b.we_i = we;
        bus_b.adr_i = adr; bus_b.sel_i = sel; bus_b.dat_i = dat;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus_b.ack_o && lat < 10);
        rd = bus_b.dat_o;
        step();
        bus_b.cyc_i = 0; bus_b.stb_i = 0; bus_b.we_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] rd;
        int          lat;
        int          seen;

        rst_n = 0;
        bus_a.cyc_i = 0; bus_a.stb_i = 0; bus_a.we_i = 0;
        bus_a.adr_i = 0; bus_a.sel_i = 0; bus_a.dat_i = 0;
        bus_b.cyc_i = 0; bus_b.stb_i = 0; bus_b.we_i = 0;
        bus_b.adr_i = 0; bus_b.sel_i = 0; bus_b.dat_i = 0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_ack", 32'(bus_a.ack_o), 32'd0);
        chk("rst_err", 32'(bus_a.err_o), 32'd0);
        chk("rst_dat", bus_a.dat_o, 32'd0);
        chk("rst_irq", 32'(irq_a), 32'd0);
        chk("rst_state", 32'(dbg_a), 32'(S_IDLE));
        rst_n = 1;
        step();

        // Reset values of the register map.
        acc_a(0, 4'd3, 4'hF, 0, rd);
        chk("reset_prescale", rd, 32'h10);
        for (int a = 0; a < 8; a++) begin
            if (a != 3) begin
                acc_a(0, 4'(a), 4'hF, 0, rd);
                chk("reset_reg_zero", rd, 32'd0);
            end
        end

        // Wrap: COUNT near the top, prescale 0, wrap irq enabled.
        acc_a(1, 4'd2, 4'hF, 32'hFFFF_FFFE, rd);
        acc_a(1, 4'd3, 4'hF, 32'h0, rd);
        acc_a(1, 4'd0, 4'hF, 32'h101, rd);
        step();
        step();
        step();
        chk("wrap_irq", 32'(irq_a), 32'd1);
        acc_a(0, 4'd1, 4'hF, 0, rd);
        chk("wrap_status", rd, 32'h1F);

        // Compare match at prescale 3.
        acc_a(1, 4'd0, 4'hF, 32'h0, rd);
        acc_a(1, 4'd1, 4'hF, 32'h1F, rd);
        acc_a(1, 4'd2, 4'hF, 32'h0, rd);
        acc_a(1, 4'd3, 4'hF, 32'h3, rd);
        acc_a(1, 4'd5, 4'hF, 32'h5, rd);
        acc_a(1, 4'd0, 4'hF, 32'h1, rd);
        repeat (19) step();
        chk("cmp1_not_yet", 32'(dut_a.bus.ack_o), 32'd0);
        step();
        acc_a(0, 4'd1, 4'hF, 0, rd);
        chk("cmp1_status", rd, 32'h2);
        acc_a(1, 4'd1, 4'hF, 32'h2, rd);
        acc_a(0, 4'd1, 4'hF, 0, rd);
        chk("cmp1_w1c", rd, 32'h0);

        // W1C landing on the same edge as a new match: the flag stays set.
        acc_a(1, 4'd3, 4'hF, 32'h0, rd);
        acc_a(1, 4'd5, 4'hF, m_count + 32'd4, rd);
        acc_a(1, 4'd1, 4'hF, 32'h2, rd);
        acc_a(0, 4'd1, 4'hF, 0, rd);
        chk("w1c_vs_set", rd, 32'h2);

        // Byte-lane write.
        acc_a(1, 4'd6, 4'b0010, 32'hAABB_CCDD, rd);
        acc_a(0, 4'd6, 4'hF, 0, rd);
        chk("cmp2_sel", rd, 32'h0000_CC00);

        // Unmapped read and write.
        acc_a(0, 4'd9, 4'hF, 0, rd);
        chk("unmapped_rd", rd, 32'd0);
        acc_a(1, 4'd12, 4'hF, 32'h1234_5678, rd);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [3:0]  a;
            logic [3:0]  s;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                a = 4'($urandom_range(0, 15));
                acc_a(0, a, 4'hF, 0, rd);
            end else begin
                a = 4'($urandom_range(0, 8));
                s = 4'($urandom_range(1, 15));
                d = $urandom;
                if (a == 4'd3) begin
                    d = 32'($urandom_range(0, 3));
                    s = 4'hF;
                end else if (a >= 4'd4 && a <= 4'd7) begin
                    d = m_count + 32'($urandom_range(1, 12));
                end
                acc_a(1, a, s, d, rd);
            end
            repeat ($urandom_range(0, 4)) step();
        end

        // Wait-state instance: latency and data.
        acc_b(1, 4'd7, 4'hF, 32'hDEAD_BEEF, lat, rd);
        chk("b_wr_latency", 32'(lat), 32'd4);
        acc_b(0, 4'd7, 4'hF, 0, lat, rd);
        chk("b_rd_latency", 32'(lat), 32'd4);
        chk("b_rd_data", rd, 32'hDEAD_BEEF);

        // Abandoned write during wait states.
        bus_b.cyc_i = 1; bus_b.stb_i = 1; bus_b.we_i = 1;
        bus_b.adr_i = 4'd4; bus_b.sel_i = 4'hF; bus_b.dat_i = 32'h55;
        step();
        chk("b_in_wait", 32'(dbg_b), 32'(S_WAIT));
        step();
        bus_b.cyc_i = 0; bus_b.stb_i = 0; bus_b.we_i = 0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus_b.ack_o) seen++;
        end
        chk("b_abort_no_ack", 32'(seen), 32'd0);
        acc_b(0, 4'd4, 4'hF, 0, lat, rd);
        chk("b_abort_unchanged", rd, 32'd0);

        // Reset in the middle of an access on dut_a.
        bus_a.cyc_i = 1; bus_a.stb_i = 1; bus_a.we_i = 1;
        bus_a.adr_i = 4'd4; bus_a.sel_i = 4'hF; bus_a.dat_i = 32'h1234;
        step();
        rst_n = 0;
        #1;
        chk("midrst_ack", 32'(bus_a.ack_o), 32'd0);
        chk("midrst_state", 32'(dbg_a), 32'(S_IDLE));
        model_reset();
        bus_a.cyc_i = 0; bus_a.stb_i = 0; bus_a.we_i = 0;
        step();
        step();
        rst_n = 1;
        step();
        acc_a(0, 4'd4, 4'hF, 0, rd);
        chk("midrst_cmp0", rd, 32'd0);
        acc_a(0, 4'd3, 4'hF, 0, rd);
        chk("midrst_prescale", rd, 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
